// File: rtl/multiplier_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// The signed variant is selected with MULTIPLIER_SIGNED_EN.
package multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Datapath: operand registers, accumulator, one adder/subtractor and the shifter.
// Define MULTIPLIER_SIGNED_EN for two's complement operands.
module mult_shift_add_dp
  import multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               last,
  input  logic [WIDTH-1:0]   md,
  input  logic [WIDTH-1:0]   mr,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0]   md_q, md_d;
  logic [WIDTH-1:0]   mr_q, mr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;
  logic               unused_lsb;

  always_comb begin
    addend = mr_q[0] ? md_q : '0;
`ifdef MULTIPLIER_SIGNED_EN
    // Sign-extend both sides; the sign bit of mr carries negative weight, so subtract last.
    if (last) begin
      sum = {acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]} - {addend[WIDTH-1], addend};
    end else begin
      sum = {acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]} + {addend[WIDTH-1], addend};
    end
`else
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
`endif
    // The extra sum bit becomes the new MSB, which gives the carry-in or sign-extending shift.
    shifted    = {sum, acc_q[WIDTH-1:0]};
    acc_next   = shifted[2*WIDTH:1];
    unused_lsb = shifted[0] ^ last;
  end

  always_comb begin
    md_d  = md_q;
    mr_d  = mr_q;
    acc_d = acc_q;
    if (load) begin
      md_d  = md;
      mr_d  = mr;
      acc_d = '0;
    end else if (step) begin
      mr_d  = mr_q >> 1;
      acc_d = acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_q  <= '0;
      mr_q  <= '0;
      acc_q <= '0;
    end else begin
      md_q  <= md_d;
      mr_q  <= mr_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/multiplier_8x8.sv
// Sequential shift-and-add multiplier: control FSM, iteration counter and product register.
// Define MULTIPLIER_SIGNED_EN for signed operands; latency and handshake are unchanged.
module multiplier_8x8
  import multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   md,
  input  logic [WIDTH-1:0]   mr,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] acc_next;
  logic               load;
  logic               step;
  logic               last;

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load = (state_q == IDLE) && start;
    step = (state_q == BUSY);
    done = (state_q == DONE);
  end

  always_comb begin
    cnt_d     = cnt_q;
    product_d = product_q;
    if (load) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Only the final iteration's accumulator is ever published.
    if (step && last) begin
      product_d = acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

  mult_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .last    (last),
    .md      (md),
    .mr      (mr),
    .acc_next(acc_next)
  );

endmodule

// File: tb/tb_multiplier_8x8.sv
// Directed self-checking bench for multiplier_8x8 (signed vectors when MULTIPLIER_SIGNED_EN is defined).
module tb_multiplier_8x8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  md;
  logic [7:0]  mr;
  logic [15:0] product;
  logic        done;

  int checks   = 0;
  int failures = 0;

  multiplier_8x8 dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md     (md),
    .mr     (mr),
    .product(product),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation with a one-cycle start pulse; checks latency, stability, result and hold.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                       input string tag);
    logic [15:0] prev;
    int          n;
    bit          moved;
    @(negedge clk);
    md    = a;
    mr    = b;
    start = 1'b1;
    prev  = product;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    moved = 1'b0;
    while (done !== 1'b1 && n < 20) begin
      if (product !== prev) moved = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_no_intermediate"}, 32'(moved), 0);
    check({tag, "_product"}, product, exp);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_hold"}, product, exp);
    $display("op %s: 0x%02h x 0x%02h -> 0x%04h after %0d cycles", tag, a, b, product, n);
  endtask

  initial begin
    int  n;
    bit  bad;

    reset = 1'b1;
    start = 1'b0;
    md    = '0;
    mr    = '0;
    repeat (3) @(negedge clk);
    check("reset_product", product, 0);
    check("reset_done", done, 0);

    // Reset dominates a toggling start.
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = i[0];
      md    = 8'd15;
      mr    = 8'd8;
      if (product !== 16'h0000 || done !== 1'b0) bad = 1'b1;
    end
    @(negedge clk);
    if (product !== 16'h0000 || done !== 1'b0) bad = 1'b1;
    start = 1'b0;
    reset = 1'b0;
    check("reset_hold_start_ignored", 32'(bad), 0);
    @(negedge clk);
    check("post_reset_product", product, 0);
    check("post_reset_done", done, 0);
    $display("reset hold with toggling start: product=0x%04h done=%0b", product, done);

    do_op(8'd15, 8'd8, 16'h0078, "15x8");
`ifndef MULTIPLIER_SIGNED_EN
    do_op(8'd255, 8'd255, 16'hFE01, "255x255");
`endif
    do_op(8'd0, 8'd200, 16'h0000, "0x200");
    do_op(8'd1, 8'd1, 16'h0001, "1x1");

    // Operand changes and a start pulse while BUSY must not disturb the operation.
    @(negedge clk);
    md    = 8'd12;
    mr    = 8'd10;
    start = 1'b1;
    @(negedge clk);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      if (n == 2) begin
        md    = 8'd99;
        mr    = 8'd77;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("busy_ignore_latency", n, 8);
    check("busy_ignore_product", product, 16'h0078);
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || product !== 16'h0078) bad = 1'b1;
    end
    check("busy_ignore_no_second_op", 32'(bad), 0);
    $display("op 12x10 with busy start: product=0x%04h", product);

    // Reset in the 4th BUSY cycle clears product and abandons the operation.
    @(negedge clk);
    md    = 8'd15;
    mr    = 8'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midop_reset_product", product, 0);
    check("midop_reset_done", done, 0);
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || product !== 16'h0000) bad = 1'b1;
    end
    check("midop_reset_abandoned", 32'(bad), 0);
    $display("mid-operation reset: product=0x%04h", product);
    do_op(8'd3, 8'd7, 16'h0015, "3x7");

    // Held start: back-to-back operations ten cycles apart.
    @(negedge clk);
    md    = 8'd2;
    mr    = 8'd3;
    start = 1'b1;
    @(negedge clk);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held_first_latency", n, 8);
    check("held_first_product", product, 16'h0006);
    $display("op held 2x3 -> 0x%04h", product);
    md = 8'd4;
    mr = 8'd5;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 30);
    start = 1'b0;
    check("held_period", n, 10);
    check("held_second_product", product, 16'h0014);
    $display("op held 4x5 -> 0x%04h, %0d cycles after previous done", product, n);
    @(negedge clk);
    check("held_done_drop", done, 0);

`ifdef MULTIPLIER_SIGNED_EN
    do_op(8'hFD, 8'h05, 16'hFFF1, "s_m3x5");
    do_op(8'h80, 8'h80, 16'h4000, "s_m128xm128");
    do_op(8'h07, 8'hFE, 16'hFFF2, "s_7xm2");
    do_op(8'hFF, 8'hFF, 16'h0001, "s_m1xm1");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
